// File: rtl/s2neuron_pkg.sv
// s2neuron_pkg: definitions shared by the s2neuron sequencer and its users.
//   - state_t  : sequencer FSM states
//   - DEF_*    : default lane count, sequence length and word width
//   - aw_calc  : buffer address width for a given sequence length
package s2neuron_pkg;

  localparam int DEF_N    = 8;   // neuron lanes
  localparam int DEF_S    = 8;   // elements per accumulation
  localparam int DEF_WORD = 32;  // data word width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACC,
    ST_FIN,
    ST_DONE
  } state_t;

  // Address width wide enough to index S elements, and never zero.
  function automatic int aw_calc(input int s);
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/s2neuron_seq.sv
// s2neuron_seq: sequencer for an N-lane s2neuron datapath.
// On start it clears the neuron, streams S (H, W-row) pairs from two
// synchronous-read buffers (one pair per clock), tells the neuron it is
// finished, latches the N result words and pulses done.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, abort       layer-controller handshake; busy/done status back
//   rd_en, rd_addr     read strobe / element index for the H and W buffers
//   h_rdata, w_rdata   buffer read data, valid the cycle after rd_en
//   nrn_H, nrn_W       operands to the neuron (zero outside accumulation)
//   nrn_reset          clears the neuron accumulators
//   nrn_finished       neuron holds and presents its sums on nrn_Y
//   nrn_Y              neuron results
//   y_out              registered result, valid while done is high
module s2neuron_seq
  import s2neuron_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int S  = DEF_S,
  parameter int n  = DEF_WORD,
  parameter int AW = aw_calc(S)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [n-1:0]    h_rdata,
  input  logic [N*n-1:0]  w_rdata,
  output logic [n-1:0]    nrn_H,
  output logic [N*n-1:0]  nrn_W,
  output logic            nrn_reset,
  output logic            nrn_finished,
  input  logic [N*n-1:0]  nrn_Y,
  output logic [N*n-1:0]  y_out
);

  // Exact-equality exit compare: for power-of-two S this is all-ones,
  // so any magnitude trick based on wrap-around would be wrong.
  localparam logic [AW-1:0] K_LAST = AW'(S - 1);

  state_t          state_reg, state_next;
  logic [AW-1:0]   k_reg, k_next;

  // Outputs are computed from the next state and registered, so every
  // control output is a flop rather than a decode of the state vector.
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            rd_en_reg, rd_en_next;
  logic [AW-1:0]   rd_addr_reg, rd_addr_next;
  logic            nrn_reset_reg, nrn_reset_next;
  logic            nrn_finished_reg, nrn_finished_next;
  logic            acc_sel_reg, acc_sel_next;
  logic [N*n-1:0]  y_out_reg;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      k_reg            <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      rd_en_reg        <= 1'b0;
      rd_addr_reg      <= '0;
      nrn_reset_reg    <= 1'b1;
      nrn_finished_reg <= 1'b0;
      acc_sel_reg      <= 1'b0;
      y_out_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      k_reg            <= k_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      rd_en_reg        <= rd_en_next;
      rd_addr_reg      <= rd_addr_next;
      nrn_reset_reg    <= nrn_reset_next;
      nrn_finished_reg <= nrn_finished_next;
      acc_sel_reg      <= acc_sel_next;
      // The neuron presents its final sums during FIN; an abort there
      // discards the run and leaves the previous result in place.
      if (state_reg == ST_FIN && !abort) begin
        y_out_reg <= nrn_Y;
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    case (state_reg)
      ST_IDLE: begin
        // abort is deliberately not looked at here: start wins.
        if (start) begin
          state_next = ST_CLEAR;
          k_next     = '0;
        end
      end
      ST_CLEAR: begin
        state_next = abort ? ST_IDLE : ST_ACC;
        k_next     = '0;
      end
      ST_ACC: begin
        if (abort) begin
          state_next = ST_IDLE;
          k_next     = '0;
        end else if (k_reg == K_LAST) begin
          state_next = ST_FIN;
          k_next     = '0;
        end else begin
          k_next = k_reg + AW'(1);
        end
      end
      ST_FIN: begin
        state_next = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        k_next     = '0;
      end
    endcase
  end

  // ---------------- output logic (pre-register) ----------------
  always_comb begin
    busy_next         = (state_next != ST_IDLE);
    done_next         = (state_next == ST_DONE);
    nrn_reset_next    = (state_next == ST_IDLE) || (state_next == ST_CLEAR);
    nrn_finished_next = (state_next == ST_FIN) || (state_next == ST_DONE);
    acc_sel_next      = (state_next == ST_ACC);
    rd_en_next        = 1'b0;
    rd_addr_next      = rd_addr_reg;
    case (state_next)
      ST_CLEAR: begin
        // Prime element 0 so it arrives for the first ACC cycle.
        rd_en_next   = 1'b1;
        rd_addr_next = '0;
      end
      ST_ACC: begin
        // Prefetch k+1 while there is one; the last element was already
        // requested, so the address simply holds.
        if (k_next != K_LAST) begin
          rd_en_next   = 1'b1;
          rd_addr_next = k_next + AW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Operand gating: only the registered ACC select lets buffer data
  // through, so nothing stray is accumulated in other states.
  assign nrn_H = acc_sel_reg ? h_rdata : '0;
  assign nrn_W = acc_sel_reg ? w_rdata : '0;

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign rd_en        = rd_en_reg;
  assign rd_addr      = rd_addr_reg;
  assign nrn_reset    = nrn_reset_reg;
  assign nrn_finished = nrn_finished_reg;
  assign y_out        = y_out_reg;

endmodule

// File: tb/tb_s2neuron_seq.sv
// tb_s2neuron_seq: directed bench for s2neuron_seq with N=2, n=32 in two
// builds (S=4 and S=1), behavioural buffers and a behavioural neuron.
module tb_s2neuron_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, start1;

  int checks = 0;
  int errors = 0;

  // ---------------- S=4 instance ----------------
  logic        busy, done, rd_en, nrn_reset, nrn_finished;
  logic [1:0]  rd_addr;
  logic [31:0] h_rdata, nrn_H;
  logic [63:0] w_rdata, nrn_W, nrn_Y, y_out;
  logic [31:0] acc0, acc1;
  logic [31:0] h_mem [4];
  logic [31:0] w0_mem [4];
  logic [31:0] w1_mem [4];

  s2neuron_seq #(.N(2), .S(4), .n(32)) dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .h_rdata(h_rdata), .w_rdata(w_rdata),
    .nrn_H(nrn_H), .nrn_W(nrn_W), .nrn_reset(nrn_reset),
    .nrn_finished(nrn_finished), .nrn_Y(nrn_Y), .y_out(y_out)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      h_rdata <= h_mem[rd_addr];
      w_rdata <= {w1_mem[rd_addr], w0_mem[rd_addr]};
    end
  end

  always @(posedge clk) begin
    if (nrn_reset) begin
      acc0 <= 32'd0;
      acc1 <= 32'd0;
    end else if (!nrn_finished) begin
      acc0 <= acc0 + nrn_W[31:0]  * nrn_H;
      acc1 <= acc1 + nrn_W[63:32] * nrn_H;
    end
  end
  assign nrn_Y = {acc1, acc0};

  // ---------------- S=1 instance ----------------
  logic        busy1, done1, rd_en1, nrn_reset1, nrn_finished1;
  logic [0:0]  rd_addr1;
  logic [31:0] h_rdata1, nrn_H1;
  logic [63:0] w_rdata1, nrn_W1, nrn_Y1, y_out1;
  logic [31:0] acc10, acc11;

  s2neuron_seq #(.N(2), .S(1), .n(32)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .h_rdata(h_rdata1), .w_rdata(w_rdata1),
    .nrn_H(nrn_H1), .nrn_W(nrn_W1), .nrn_reset(nrn_reset1),
    .nrn_finished(nrn_finished1), .nrn_Y(nrn_Y1), .y_out(y_out1)
  );

  // Single-element buffers: H={5}, W={3,7}.
  always @(posedge clk) begin
    if (rd_en1) begin
      h_rdata1 <= (rd_addr1 == 1'b0) ? 32'd5 : 32'd0;
      w_rdata1 <= (rd_addr1 == 1'b0) ? {32'd7, 32'd3} : 64'd0;
    end
  end

  always @(posedge clk) begin
    if (nrn_reset1) begin
      acc10 <= 32'd0;
      acc11 <= 32'd0;
    end else if (!nrn_finished1) begin
      acc10 <= acc10 + nrn_W1[31:0]  * nrn_H1;
      acc11 <= acc11 + nrn_W1[63:32] * nrn_H1;
    end
  end
  assign nrn_Y1 = {acc11, acc10};

  // ---------------- helpers ----------------
  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_h(input logic [31:0] a, b, c, d);
    h_mem[0] = a; h_mem[1] = b; h_mem[2] = c; h_mem[3] = d;
  endtask

  // One full run from IDLE; c counts cycles after the start edge t0.
  // ACC occupies c=2..5, FIN c=6, DONE c=7.
  task automatic run_basic(input string tag, input logic [31:0] e0, e1,
                           input bit poke);
    int          n_rd;
    logic [1:0]  addrs [4];
    n_rd = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      start = poke && (c == 3);  // must be ignored while busy
      check_val($sformatf("%s.busy%0d", tag, c), busy, 1'b1);
      check_val($sformatf("%s.done%0d", tag, c), done, (c == 7));
      if (c >= 2 && c <= 5) begin
        check_val($sformatf("%s.h%0d", tag, c), nrn_H, h_mem[c-2]);
        check_val($sformatf("%s.w%0d", tag, c), nrn_W,
                  {w1_mem[c-2], w0_mem[c-2]});
      end else begin
        check_val($sformatf("%s.h0_%0d", tag, c), nrn_H, 0);
        check_val($sformatf("%s.w0_%0d", tag, c), nrn_W, 0);
      end
      if (rd_en) begin
        if (n_rd < 4) addrs[n_rd] = rd_addr;
        n_rd++;
      end
      step();
    end
    start = 1'b0;
    check_val($sformatf("%s.nrd", tag), n_rd, 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s.addr%0d", tag, i), addrs[i], i);
    check_val($sformatf("%s.y", tag), y_out, {e1, e0});
    check_val($sformatf("%s.idle", tag), busy, 1'b0);
    $display("run %s: y_out lane0=%0d lane1=%0d", tag, y_out[31:0], y_out[63:32]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    load_h(1, 2, 3, 4);
    w0_mem[0] = 1; w0_mem[1] = 1; w0_mem[2] = 1; w0_mem[3] = 1;
    w1_mem[0] = 2; w1_mem[1] = 0; w1_mem[2] = 0; w1_mem[3] = 1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.rd_en", rd_en, 0);
    check_val("rst.rd_addr", rd_addr, 0);
    check_val("rst.nrn_reset", nrn_reset, 1);
    check_val("rst.nrn_fin", nrn_finished, 0);
    check_val("rst.y", y_out, 0);
    check_val("rst.s1_busy", busy1, 0);
    check_val("rst.s1_y", y_out1, 0);
    $display("reset: checked");

    // Basic run with a start pulse while busy (must be ignored)
    run_basic("basic", 10, 6, 1'b1);

    // Back-to-back with start held high; H swapped before the second run
    start = 1'b1;
    step();
    for (int c = 1; c <= 15; c++) begin
      start = (c < 9);
      if (c == 6) load_h(4, 3, 2, 1);
      check_val($sformatf("b2b.busy%0d", c), busy, (c != 8));
      check_val($sformatf("b2b.done%0d", c), done, (c == 7 || c == 15));
      if (c == 8) check_val("b2b.y1", y_out, {32'd6, 32'd10});
      step();
    end
    start = 1'b0;
    check_val("b2b.y2", y_out, {32'd9, 32'd10});
    check_val("b2b.idle", busy, 0);
    $display("run b2b: y_out lane0=%0d lane1=%0d", y_out[31:0], y_out[63:32]);

    // Abort in the second ACC cycle
    load_h(1, 2, 3, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("abort.busy", busy, 0);
    check_val("abort.done", done, 0);
    check_val("abort.y", y_out, {32'd9, 32'd10});
    for (int c = 0; c < 3; c++) begin
      check_val($sformatf("abort.nodone%0d", c), done, 0);
      step();
    end
    $display("run abort: y_out lane0=%0d lane1=%0d", y_out[31:0], y_out[63:32]);

    // start and abort together in IDLE: start wins; fresh sums follow
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_val("sw.busy", busy, 1);
    for (int c = 2; c <= 7; c++) begin
      step();
      check_val($sformatf("sw.done%0d", c), done, (c == 7));
    end
    step();
    check_val("sw.y", y_out, {32'd6, 32'd10});
    $display("run start_wins: y_out lane0=%0d lane1=%0d", y_out[31:0], y_out[63:32]);

    // Reset in the third ACC cycle
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mrst.busy", busy, 0);
    check_val("mrst.done", done, 0);
    check_val("mrst.rd_en", rd_en, 0);
    check_val("mrst.rd_addr", rd_addr, 0);
    check_val("mrst.nrn_reset", nrn_reset, 1);
    check_val("mrst.nrn_fin", nrn_finished, 0);
    check_val("mrst.y", y_out, 0);
    $display("run midreset: y_out lane0=%0d lane1=%0d", y_out[31:0], y_out[63:32]);
    run_basic("restart", 10, 6, 1'b0);

    // S=1 build: CLEAR c=1, ACC c=2, FIN c=3, DONE c=4
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check_val($sformatf("s1.busy%0d", c), busy1, 1);
      check_val($sformatf("s1.done%0d", c), done1, (c == 4));
      check_val($sformatf("s1.rd_en%0d", c), rd_en1, (c == 1));
      check_val($sformatf("s1.h%0d", c), nrn_H1, (c == 2) ? 32'd5 : 32'd0);
      step();
    end
    check_val("s1.y", y_out1, {32'd35, 32'd15});
    check_val("s1.idle", busy1, 0);
    $display("run s1: y_out lane0=%0d lane1=%0d", y_out1[31:0], y_out1[63:32]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2neuron_seq.md
Name: s2neuron_seq

Overview:
- Sequencer for the N-lane s2neuron datapath.
- On start it:
  - clears the neuron accumulators;
  - streams S input/weight pairs from two synchronous-read buffers, one pair per clock;
  - asserts the neuron's finished input;
  - latches the N result words.
- Sits between the layer controller (start/done handshake) and the H/W storage buffers plus one s2neuron instance.

Parameters:
- N, 8, number of neuron lanes (one MAC per lane).
- S, 8, input elements per accumulation (sequence length); legal range S >= 1.
- n, 32, data word width of H and of each W/Y lane.
- AW, max(1,$clog2(S)), buffer address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one accumulation; sampled only in IDLE
- abort  in  1  cancel a running accumulation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; y_out valid
- rd_en  out  1  buffer read strobe
- rd_addr  out  AW  element index k for both buffers
- h_rdata  in  n  H[k]; valid the cycle after rd_en
- w_rdata  in  N*n  W row k, lane i at [n*(i+1)-1 -: n]; same timing as h_rdata
- nrn_H  out  n  to s2neuron H
- nrn_W  out  N*n  to s2neuron W
- nrn_reset  out  1  to s2neuron reset
- nrn_finished  out  1  to s2neuron finished
- nrn_Y  in  N*n  from s2neuron Y
- y_out  out  N*n  registered result

Behaviour:
- Neuron contract:
  - nrn_reset=1 clears all lane accumulators.
  - With nrn_reset=0 and nrn_finished=0, each clock adds nrn_W[i]*nrn_H.
  - With nrn_finished=1, the neuron holds its sum and presents it on nrn_Y.
- State IDLE:
  - busy=0, nrn_reset=1, nrn_finished=0, rd_en=0.
  - start=1 moves to CLEAR.
- State CLEAR (1 cycle):
  - nrn_reset=1; rd_en=1, rd_addr=0 (primes element 0).
  - Element counter k is set to 0.
  - Next state is ACC.
- State ACC (exactly S cycles, k=0..S-1):
  - nrn_reset=0, nrn_H=h_rdata, nrn_W=w_rdata.
  - rd_en=1 with rd_addr=k+1 while k+1<S; otherwise rd_en=0 and rd_addr holds.
  - k increments every cycle; at k=S-1 the next state is FIN.
- State FIN (1 cycle):
  - nrn_finished=1.
  - y_out <= nrn_Y at the end of this cycle.
  - Next state is DONE.
- State DONE (1 cycle):
  - done=1, nrn_finished=1, busy=1.
  - Next state is IDLE.
- nrn_H and nrn_W are forced to 0 outside ACC, so no stray products are accumulated.
- Latency: start sampled at edge t0 gives done=1 during cycle t0+S+3. Back-to-back throughput is one result per S+4 cycles.
- start:
  - Ignored outside IDLE.
  - start held high re-launches on the first IDLE cycle after DONE.
- abort:
  - In CLEAR, ACC or FIN: next state is IDLE, no done pulse, y_out unchanged, k cleared.
  - Ignored in IDLE and DONE.
  - abort and start together in IDLE: start wins (abort is ignored in IDLE).
- reset:
  - Sync reset at any edge, including mid-ACC.
  - State=IDLE, k=0, y_out=0, done=0, busy=0, rd_en=0, rd_addr=0, nrn_reset=1, nrn_finished=0.
- S=1: ACC lasts one cycle and no read is issued in ACC.
- Counter:
  - Width AW; never wraps, because the exit occurs at S-1.
  - When S is a power of two, S-1 is all-ones, so the compare must be exact equality.
- All outputs are registered except nrn_H and nrn_W. Those are a registered-select mux of the buffer data, with no additional register stage.

Decomposition:
- Shared package s2neuron_pkg:
  - state enum (IDLE, CLEAR, ACC, FIN, DONE);
  - default N/S/n constants;
  - AW derivation function.
- No sub-module needed; the block is a single FSM plus counter.
- An optional top-level wrapper instantiates s2neuron_seq alongside s2neuron.

Test Plan:
- Common bench setup:
  - N=2, S=4, n=32.
  - Integer behavioural neuron model.
  - H={1,2,3,4}.
  - W lane0={1,1,1,1}, lane1={2,0,0,1}.
- Basic run: start pulse at t0 → rd_addr sequence 0,1,2,3; done at t0+7; y_out lane0=10, lane1=6; busy high for t0+1..t0+7.
- Back-to-back: start held high, buffers changed so H={4,3,2,1} before the second run → second done 8 cycles after the first; lane0=10, lane1=9. No accumulator carry-over between runs.
- Abort: abort during the 2nd ACC cycle → IDLE next cycle, no done, y_out keeps its previous value. A following start gives the correct fresh sums.
- Reset mid-ACC: reset at the 3rd ACC cycle → all outputs take their reset values next cycle, y_out=0. Restart yields 10/6.
- S=1 build: H={5}, W={3,7} → done at t0+4; y_out=15/35; no rd_en while in ACC.
- Protocol check: start pulsed while busy has no effect; nrn_H and nrn_W are zero whenever the FSM is not in ACC.
